// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: writeback source encoding and register file geometry.
package pipe_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        WB_ALU   = 3'b000,
        WB_MEM   = 3'b001,
        WB_PC4   = 3'b010,
        WB_IMM   = 3'b011,
        WB_PCIMM = 3'b100
    } wb_src_e;

endpackage

// File: rtl/wb_data_select.sv
// Writeback data mux with PC adders; flags source codes outside the defined set.
module wb_data_select
    import pipe_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic [2:0]            src,
    input  logic [DATA_W-1:0]     mem_rd_data,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DM_ADDRESS-1:0] pc,
    input  logic [DATA_W-1:0]     imm,
    output logic [DATA_W-1:0]     wrt_data,
    output logic                  src_legal
);

    logic [DATA_W-1:0] pc_ext;

    // PC is widened before any add so sums wrap at DATA_W, not at the PC width.
    assign pc_ext = {{(DATA_W-DM_ADDRESS){1'b0}}, pc};

    // Select writeback value; illegal codes produce zero and are not legal.
    always_comb begin
        wrt_data  = '0;
        src_legal = 1'b1;
        case (src)
            WB_ALU:   wrt_data = alu_result;
            WB_MEM:   wrt_data = mem_rd_data;
            WB_PC4:   wrt_data = pc_ext + DATA_W'(4);
            WB_IMM:   wrt_data = imm;
            WB_PCIMM: wrt_data = pc_ext + imm;
            default: begin
                wrt_data  = '0;
                src_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/wb_commit_regfile.sv
// Writeback commit stage: architectural register file with x0 tied to zero,
// two bypassed read ports and a retired-write counter.
module wb_commit_regfile
    import pipe_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     MemRdDataIn,
    input  logic [DATA_W-1:0]     MemALUresultIn,
    input  logic                  RegWrtEnIn,
    input  logic [2:0]            RegWrtSrcIn,
    input  logic [4:0]            RegDstIn,
    input  logic [DM_ADDRESS-1:0] PCin,
    input  logic [DATA_W-1:0]     immIn,
    input  logic [4:0]            Rs1Addr,
    input  logic [4:0]            Rs2Addr,
    output logic [DATA_W-1:0]     Rs1Data,
    output logic [DATA_W-1:0]     Rs2Data,
    output logic [DATA_W-1:0]     WrtData,
    output logic                  WrtValid,
    output logic [31:0]           CommitCount
);

    logic                          src_legal;
    logic [DATA_W-1:0]             regs_q [NUM_REGS];
    logic [DATA_W-1:0]             regs_d [NUM_REGS];
    logic [31:0]                   commit_count_q;
    logic [31:0]                   commit_count_d;

    wb_data_select #(
        .DM_ADDRESS (DM_ADDRESS),
        .DATA_W     (DATA_W)
    ) u_data_select (
        .src         (RegWrtSrcIn),
        .mem_rd_data (MemRdDataIn),
        .alu_result  (MemALUresultIn),
        .pc          (PCin),
        .imm         (immIn),
        .wrt_data    (WrtData),
        .src_legal   (src_legal)
    );

    // A commit needs enable, a defined source and a nonzero destination; reset suppresses it.
    assign WrtValid = !rst && RegWrtEnIn && src_legal && (RegDstIn != '0);

    // Next-state of the array: only the destination entry changes; entry 0 stays zero.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (WrtValid) begin
            regs_d[RegDstIn] = WrtData;
        end
        regs_d[0] = '0;
    end

    // Retired-write counter wraps naturally at 32 bits.
    always_comb begin
        commit_count_d = commit_count_q;
        if (WrtValid) begin
            commit_count_d = commit_count_q + 32'd1;
        end
    end

    // Array and counter state; reset wins over any commit presented the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            commit_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            commit_count_q <= commit_count_d;
        end
    end

    // Read ports: x0 is always zero, a same-cycle commit to the index is bypassed.
    always_comb begin
        Rs1Data = '0;
        Rs2Data = '0;
        if (!rst) begin
            if (Rs1Addr == '0) begin
                Rs1Data = '0;
            end else if (WrtValid && (Rs1Addr == RegDstIn)) begin
                Rs1Data = WrtData;
            end else begin
                Rs1Data = regs_q[Rs1Addr];
            end
            if (Rs2Addr == '0) begin
                Rs2Data = '0;
            end else if (WrtValid && (Rs2Addr == RegDstIn)) begin
                Rs2Data = WrtData;
            end else begin
                Rs2Data = regs_q[Rs2Addr];
            end
        end
    end

    assign CommitCount = commit_count_q;

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Self-checking bench for wb_commit_regfile: vector table through a scoreboard
// queue, plus hand-written reset, wrap and reset-during-commit sequences.
module tb_wb_commit_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] MemRdDataIn;
    logic [31:0] MemALUresultIn;
    logic        RegWrtEnIn;
    logic [2:0]  RegWrtSrcIn;
    logic [4:0]  RegDstIn;
    logic [8:0]  PCin;
    logic [31:0] immIn;
    logic [4:0]  Rs1Addr;
    logic [4:0]  Rs2Addr;
    logic [31:0] Rs1Data;
    logic [31:0] Rs2Data;
    logic [31:0] WrtData;
    logic        WrtValid;
    logic [31:0] CommitCount;

    wb_commit_regfile #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .MemRdDataIn    (MemRdDataIn),
        .MemALUresultIn (MemALUresultIn),
        .RegWrtEnIn     (RegWrtEnIn),
        .RegWrtSrcIn    (RegWrtSrcIn),
        .RegDstIn       (RegDstIn),
        .PCin           (PCin),
        .immIn          (immIn),
        .Rs1Addr        (Rs1Addr),
        .Rs2Addr        (Rs2Addr),
        .Rs1Data        (Rs1Data),
        .Rs2Data        (Rs2Data),
        .WrtData        (WrtData),
        .WrtValid       (WrtValid),
        .CommitCount    (CommitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  src;
        logic [4:0]  dst;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [8:0]  pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_wd;
        logic        exp_valid;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
    } vec_t;

    typedef struct {
        logic [31:0] wd;
        logic        valid;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] count;
    } exp_t;

    localparam int NVEC = 13;
    vec_t  vecs [NVEC];
    exp_t  sb_q [$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic [31:0] model_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic en, input logic [2:0] src, input logic [4:0] dst,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [8:0] pc,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2);
        RegWrtEnIn     = en;
        RegWrtSrcIn    = src;
        RegDstIn       = dst;
        MemALUresultIn = alu;
        MemRdDataIn    = mem;
        PCin           = pc;
        immIn          = imm;
        Rs1Addr        = rs1;
        Rs2Addr        = rs2;
    endtask

    initial begin
        exp_t e;
        // en src dst alu mem pc imm rs1 rs2 | wd valid rs1 rs2
        vecs[0]  = '{1'b1, 3'b000, 5'd3,  32'h12345678, 32'h0,  9'h000, 32'h0,        5'd3,  5'd0,
                     32'h12345678, 1'b1, 32'h12345678, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 5'd3,  32'h0,        32'h0,  9'h000, 32'h0,        5'd3,  5'd3,
                     32'h0,        1'b0, 32'h12345678, 32'h12345678};
        vecs[2]  = '{1'b1, 3'b010, 5'd4,  32'h0,        32'h0,  9'h1FC, 32'h0,        5'd4,  5'd0,
                     32'h200,      1'b1, 32'h200,      32'h0};
        vecs[3]  = '{1'b1, 3'b100, 5'd5,  32'h0,        32'h0,  9'h010, 32'hFFFFFFF0, 5'd5,  5'd4,
                     32'h0,        1'b1, 32'h0,        32'h200};
        vecs[4]  = '{1'b1, 3'b011, 5'd6,  32'h0,        32'h0,  9'h000, 32'hABCDE000, 5'd6,  5'd5,
                     32'hABCDE000, 1'b1, 32'hABCDE000, 32'h0};
        vecs[5]  = '{1'b1, 3'b001, 5'd8,  32'h0,        32'h55, 9'h000, 32'h0,        5'd8,  5'd6,
                     32'h55,       1'b1, 32'h55,       32'hABCDE000};
        vecs[6]  = '{1'b1, 3'b000, 5'd0,  32'hFFFFFFFF, 32'h0,  9'h000, 32'h0,        5'd0,  5'd0,
                     32'hFFFFFFFF, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 3'b110, 5'd7,  32'h777,      32'h0,  9'h000, 32'h0,        5'd7,  5'd8,
                     32'h0,        1'b0, 32'h0,        32'h55};
        vecs[8]  = '{1'b1, 3'b000, 5'd9,  32'hCAFE,     32'h0,  9'h000, 32'h0,        5'd9,  5'd9,
                     32'hCAFE,     1'b1, 32'hCAFE,     32'hCAFE};
        vecs[9]  = '{1'b0, 3'b000, 5'd9,  32'hBEEF,     32'h0,  9'h000, 32'h0,        5'd9,  5'd9,
                     32'hBEEF,     1'b0, 32'hCAFE,     32'hCAFE};
        vecs[10] = '{1'b0, 3'b000, 5'd0,  32'h0,        32'h0,  9'h000, 32'h0,        5'd7,  5'd3,
                     32'h0,        1'b0, 32'h0,        32'h12345678};
        vecs[11] = '{1'b1, 3'b010, 5'd10, 32'h0,        32'h0,  9'h1FF, 32'h0,        5'd10, 5'd4,
                     32'h203,      1'b1, 32'h203,      32'h200};
        vecs[12] = '{1'b1, 3'b101, 5'd3,  32'h1,        32'h0,  9'h000, 32'h0,        5'd3,  5'd0,
                     32'h0,        1'b0, 32'h12345678, 32'h0};

        rst = 1'b1;
        drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 5'd0, 5'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_count_init", CommitCount, 32'h0);
        chk("reset_valid", {31'b0, WrtValid}, 32'h0);
        rst = 1'b0;

        // Write DEADBEEF to x5, then hold reset for two cycles with a commit presented.
        drive(1'b1, 3'b000, 5'd5, 32'hDEADBEEF, 32'h0, 9'h0, 32'h0, 5'd5, 5'd0);
        @(posedge clk); #1;
        @(negedge clk);
        drive(1'b0, 3'b000, 5'd5, 32'h0, 32'h0, 9'h0, 32'h0, 5'd5, 5'd0);
        #2;
        chk("pre_reset_x5", Rs1Data, 32'hDEADBEEF);
        chk("pre_reset_count", CommitCount, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 3'b000, 5'd5, 32'h11111111, 32'h0, 9'h0, 32'h0, 5'd5, 5'd5);
        #2;
        chk("in_reset_rs1", Rs1Data, 32'h0);
        chk("in_reset_valid", {31'b0, WrtValid}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 5'd5, 5'd0);
        #2;
        chk("post_reset_x5", Rs1Data, 32'h0);
        chk("post_reset_count", CommitCount, 32'h0);
        model_count = 0;

        // Vector table through the scoreboard.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].src, vecs[i].dst, vecs[i].alu, vecs[i].mem,
                  vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
            if (vecs[i].exp_valid) model_count = model_count + 32'd1;
            sb_q.push_back('{vecs[i].exp_wd, vecs[i].exp_valid, vecs[i].exp_rs1,
                             vecs[i].exp_rs2, model_count});
            #2;
            e = sb_q.pop_front();
            chk($sformatf("v%0d_wrtdata", i), WrtData, e.wd);
            chk($sformatf("v%0d_wrtvalid", i), {31'b0, WrtValid}, {31'b0, e.valid});
            chk($sformatf("v%0d_rs1", i), Rs1Data, e.rs1);
            chk($sformatf("v%0d_rs2", i), Rs2Data, e.rs2);
            @(posedge clk); #1;
            chk($sformatf("v%0d_count", i), CommitCount, e.count);
        end

        // Counter wrap: preload all-ones, then one valid commit.
        @(negedge clk);
        drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 5'd0, 5'd0);
        force dut.commit_count_q = 32'hFFFFFFFF;
        #1;
        release dut.commit_count_q;
        #1;
        chk("wrap_preload", CommitCount, 32'hFFFFFFFF);
        drive(1'b1, 3'b000, 5'd12, 32'h42, 32'h0, 9'h0, 32'h0, 5'd12, 5'd0);
        @(posedge clk); #1;
        chk("wrap_count_zero", CommitCount, 32'h0);
        @(negedge clk);
        drive(1'b1, 3'b000, 5'd13, 32'h43, 32'h0, 9'h0, 32'h0, 5'd12, 5'd0);
        #2;
        chk("wrap_x12_array", Rs1Data, 32'h42);
        @(posedge clk); #1;
        chk("wrap_count_one", CommitCount, 32'h1);

        // Reset during a valid commit: write dropped, counter zeroed.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 3'b000, 5'd11, 32'h1234, 32'h0, 9'h0, 32'h0, 5'd11, 5'd11);
        #2;
        chk("rst_commit_valid", {31'b0, WrtValid}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 9'h0, 32'h0, 5'd11, 5'd13);
        #2;
        chk("rst_commit_x11", Rs1Data, 32'h0);
        chk("rst_commit_x13", Rs2Data, 32'h0);
        chk("rst_commit_count", CommitCount, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
